// File: rtl/vote_pkg.sv
// Shared definitions for the ballot capture front end: voter count and FSM state encoding.
package vote_pkg;

  localparam int NUM_VOTERS = 4;

  typedef logic [1:0] vote_state_t;

  localparam vote_state_t ST_IDLE = 2'd0;
  localparam vote_state_t ST_OPEN = 2'd1;
  localparam vote_state_t ST_DONE = 2'd2;

endpackage

// File: rtl/vote_ballot_capture_if.sv
// Voter-side bundle: START request, four raw switches, frozen ballot and status flags.
interface vote_ballot_capture_if;

  logic start;
  logic w_in;
  logic x_in;
  logic y_in;
  logic z_in;
  logic w;
  logic x;
  logic y;
  logic z;
  logic open;
  logic valid;

  modport master (
    output start, w_in, x_in, y_in, z_in,
    input  w, x, y, z, open, valid
  );

  modport slave (
    input  start, w_in, x_in, y_in, z_in,
    output w, x, y, z, open, valid
  );

endinterface

// File: rtl/vote_debounce.sv
// Two-flop synchroniser followed by a stability filter: the output follows the
// synchronised input only after it has disagreed for DEBOUNCE_CYCLES straight cycles.
module vote_debounce #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic filtered
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1_reg;
  logic          sync2_reg;
  logic          filt_reg;
  logic [CW-1:0] cnt_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_reg <= 1'b0;
      sync2_reg <= 1'b0;
      filt_reg  <= 1'b0;
      cnt_reg   <= '0;
    end else begin
      sync1_reg <= raw;
      sync2_reg <= sync1_reg;
      // Any cycle where the input agrees with the output restarts the count.
      if (sync2_reg != filt_reg) begin
        if (cnt_reg == CNT_MAX) begin
          filt_reg <= sync2_reg;
          cnt_reg  <= '0;
        end else begin
          cnt_reg <= cnt_reg + CW'(1);
        end
      end else begin
        cnt_reg <= '0;
      end
    end
  end

  assign filtered = filt_reg;

endmodule

// File: rtl/vote_ballot_capture.sv
// Ballot capture: debounced voter inputs are OR-accumulated over a timed window
// opened by a START edge; the frozen ballot is presented once the window closes.
module vote_ballot_capture
  import vote_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int WINDOW_CYCLES   = 1000,
  parameter int CNT_W           = 10
) (
  input  logic                  clk,
  input  logic                  rst_n,
  vote_ballot_capture_if.slave  bus
);

  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WINDOW_CYCLES - 1);

  logic [NUM_VOTERS-1:0] raw_vec;
  logic [NUM_VOTERS-1:0] filt_vec;

  assign raw_vec = {bus.z_in, bus.y_in, bus.x_in, bus.w_in};

  generate
    for (genvar gi = 0; gi < NUM_VOTERS; gi++) begin : g_db
      vote_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
      ) u_db (
        .clk      (clk),
        .rst_n    (rst_n),
        .raw      (raw_vec[gi]),
        .filtered (filt_vec[gi])
      );
    end
  endgenerate

  vote_state_t           state_reg, state_next;
  logic [CNT_W-1:0]      cnt_reg, cnt_next;
  logic [NUM_VOTERS-1:0] votes_reg, votes_next;
  logic [NUM_VOTERS-1:0] ballot_reg;
  logic                  start_q_reg;
  logic                  open_reg;
  logic                  valid_reg;
  logic                  start_edge;

  assign start_edge = bus.start & ~start_q_reg;

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    votes_next = votes_reg;
    case (state_reg)
      ST_IDLE, ST_DONE: begin
        if (start_edge) begin
          state_next = ST_OPEN;
          cnt_next   = CNT_LOAD;
          votes_next = '0;
        end
      end
      ST_OPEN: begin
        // The final cycle's votes still count before the window closes.
        votes_next = votes_reg | filt_vec;
        if (cnt_reg == '0) begin
          state_next = ST_DONE;
        end else begin
          cnt_next = cnt_reg - CNT_W'(1);
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= ST_IDLE;
      cnt_reg     <= '0;
      votes_reg   <= '0;
      start_q_reg <= 1'b0;
      open_reg    <= 1'b0;
      valid_reg   <= 1'b0;
      ballot_reg  <= '0;
    end else begin
      state_reg   <= state_next;
      cnt_reg     <= cnt_next;
      votes_reg   <= votes_next;
      start_q_reg <= bus.start;
      // Ballot stays zero outside DONE so the downstream vote circuit never sees partial votes.
      open_reg    <= (state_reg == ST_OPEN);
      valid_reg   <= (state_reg == ST_DONE);
      ballot_reg  <= (state_reg == ST_DONE) ? votes_reg : '0;
    end
  end

  assign bus.open  = open_reg;
  assign bus.valid = valid_reg;
  assign bus.w     = ballot_reg[0];
  assign bus.x     = ballot_reg[1];
  assign bus.y     = ballot_reg[2];
  assign bus.z     = ballot_reg[3];

endmodule

// File: tb/tb_vote_ballot_capture.sv
// Directed plus randomized check of vote_ballot_capture against an edge-timeline reference model.
module tb_vote_ballot_capture;
  import vote_pkg::*;

  localparam int D  = 4;
  localparam int W  = 20;
  localparam int CW = 5;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  vote_ballot_capture_if bus();

  vote_ballot_capture #(
    .DEBOUNCE_CYCLES(D),
    .WINDOW_CYCLES  (W),
    .CNT_W          (CW)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  // Reference model state, indexed by clock edge since the last reset release.
  int       k;
  bit       hist [NUM_VOTERS][$];
  bit [3:0] filt_m;
  bit       start_prev;
  bit       have_win;
  int       n;
  bit [3:0] acc;

  function automatic logic [3:0] ballot();
    return {bus.z, bus.y, bus.x, bus.w};
  endfunction

  function automatic bit raw_at(int v, int j);
    if (j < 1) return 1'b0;
    return hist[v][j-1];
  endfunction

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%02h expected=%02h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    k = 0;
    for (int v = 0; v < NUM_VOTERS; v++) hist[v].delete();
    filt_m = '0;
    start_prev = 1'b0;
    have_win = 1'b0;
    n = 0;
    acc = '0;
  endtask

  // One clock: drive inputs on the falling edge, check outputs just after the rising edge.
  task automatic tick(input bit st, input bit [3:0] raw);
    bit       exp_open, exp_valid, win_busy, flip;
    bit [3:0] exp_vote;
    @(negedge clk);
    bus.start = st;
    {bus.z_in, bus.y_in, bus.x_in, bus.w_in} = raw;
    @(posedge clk);
    #1;
    k++;
    for (int v = 0; v < NUM_VOTERS; v++) hist[v].push_back(raw[v]);
    exp_open  = have_win && (k >= n + 1) && (k <= n + W);
    exp_valid = have_win && (k >= n + W + 1);
    exp_vote  = exp_valid ? acc : 4'b0000;
    check($sformatf("outputs_edge%0d", k),
          {2'b00, ballot(), bus.open, bus.valid},
          {2'b00, exp_vote, exp_open, exp_valid});
    if (exp_open) acc = acc | filt_m;
    win_busy = have_win && (k <= n + W);
    if (st && !start_prev && !win_busy) begin
      have_win = 1'b1;
      n = k;
      acc = '0;
    end
    start_prev = st;
    for (int v = 0; v < NUM_VOTERS; v++) begin
      flip = 1'b1;
      for (int j = k - D - 1; j <= k - 2; j++)
        if (raw_at(v, j) == filt_m[v]) flip = 1'b0;
      if (flip) filt_m[v] = ~filt_m[v];
    end
  endtask

  initial begin
    bit       st;
    bit [3:0] cur;
    int       hold [NUM_VOTERS];

    bus.start = 1'b0;
    {bus.z_in, bus.y_in, bus.x_in, bus.w_in} = 4'b0000;
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs", {2'b00, ballot(), bus.open, bus.valid}, 8'h00);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    model_reset();

    // Empty window: START edge at edge 10, OPEN edges 11..30, VALID at 31.
    repeat (9) tick(1'b0, 4'b0000);
    tick(1'b1, 4'b0000);
    check("no_open_at_start_edge", {7'b0, bus.open}, 8'h00);
    for (int i = 11; i <= 31; i++) begin
      tick(1'b0, 4'b0000);
      if (i == 11) check("open_first", {7'b0, bus.open}, 8'h01);
      if (i == 30) check("open_last", {7'b0, bus.open}, 8'h01);
    end
    check("empty_valid", {7'b0, bus.valid}, 8'h01);
    check("empty_ballot", {4'b0, ballot()}, 8'h00);

    // W,Y for 10 cycles, X glitch of 3 cycles, Z rising 7 cycles before close.
    tick(1'b1, 4'b0000);
    for (int j = 1; j <= 20; j++)
      tick(1'b0, {(j >= 14), (j <= 10), (j >= 6 && j <= 8), (j <= 10)});
    tick(1'b0, 4'b1000);
    check("ballot_1101_valid", {7'b0, bus.valid}, 8'h01);
    check("ballot_1101", {4'b0, ballot()}, 8'h0D);
    repeat (12) tick(1'b0, 4'b0000);
    check("ballot_sticky", {4'b0, ballot()}, 8'h0D);

    // New START from DONE: VALID and ballot clear one edge later; Z rises 3 before close.
    tick(1'b1, 4'b0000);
    check("done_valid_hold", {7'b0, bus.valid}, 8'h01);
    for (int j = 1; j <= 20; j++) begin
      tick(1'b0, {(j >= 18), 3'b000});
      if (j == 1) check("restart_clear", {3'b0, bus.valid, ballot()}, 8'h00);
    end
    repeat (2) tick(1'b0, 4'b1000);
    check("late_z_valid", {7'b0, bus.valid}, 8'h01);
    check("late_z_ballot", {4'b0, ballot()}, 8'h00);
    repeat (10) tick(1'b0, 4'b0000);

    // START held high for 40 cycles opens exactly one window.
    repeat (40) tick(1'b1, 4'b0000);
    check("held_start_one_window", {6'b0, bus.open, bus.valid}, 8'h01);
    repeat (5) tick(1'b0, 4'b0000);

    // Randomized voter activity and START requests.
    cur = '0;
    for (int v = 0; v < NUM_VOTERS; v++) hold[v] = 1;
    for (int i = 0; i < 800; i++) begin
      for (int v = 0; v < NUM_VOTERS; v++) begin
        hold[v]--;
        if (hold[v] <= 0) begin
          cur[v]  = 1'($urandom_range(0, 1));
          hold[v] = int'($urandom_range(1, 9));
        end
      end
      st = ($urandom_range(0, 24) == 0);
      tick(st, cur);
    end
    repeat (30) tick(1'b0, 4'b0000);

    // Asynchronous reset in the middle of a window.
    tick(1'b1, 4'b0000);
    repeat (8) tick(1'b0, 4'b1111);
    check("pre_reset_open", {7'b0, bus.open}, 8'h01);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("async_reset_outputs", {2'b00, ballot(), bus.open, bus.valid}, 8'h00);
    {bus.z_in, bus.y_in, bus.x_in, bus.w_in} = 4'b0000;
    bus.start = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;
    model_reset();
    repeat (40) tick(1'b0, 4'b0000);
    check("post_reset_no_valid", {6'b0, bus.open, bus.valid}, 8'h00);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
